// File: rtl/uart_pkg.sv
// Shared UART definitions: serializer state encoding, frame width and default baud divisor.
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with registered occupancy count and a zero-latency head on rd_data.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     sw_reset,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          wr_ok, rd_ok;

  // Occupancy decides full/empty, so equal pointers are never ambiguous.
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign wr_ok   = wr_en & ~full;
  assign rd_ok   = rd_en & ~empty;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + CW'(wr_ok) - CW'(rd_ok);
    overflow_d = overflow_q | (wr_en & full);
    if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (sw_reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!sw_reset && wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter fed by a byte FIFO; line outputs are registered one cycle behind the FSM.
//   state   | meaning
//   S_IDLE  | line idle, waiting for a queued byte
//   S_START | start bit (0)
//   S_DATA  | 8 data bits, LSB first
//   S_STOP  | stop bit (1); chains straight into S_START if more bytes wait
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                         clk,
  input  logic                         sw_reset,
  input  logic                         wr_en,
  input  logic [7:0]                   wr_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(FIFO_DEPTH):0]  count,
  output logic                         overflow,
  output logic                         TxD,
  output logic                         tx_active,
  output logic                         tx_done
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  tx_state_e         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              txd_q, txd_d;
  logic              active_q, active_d;
  logic              done_q, done_d;
  logic              pop, bit_end;
  logic [7:0]        fifo_data;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .sw_reset (sw_reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (pop),
    .rd_data  (fifo_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  assign bit_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    if (state_q != S_IDLE) baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = fifo_data;
          baud_d  = '0;
          state_d = S_START;
        end
      end
      S_START: if (bit_end) state_d = S_DATA;
      S_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'(DATA_BITS - 1)) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_d = fifo_data;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    txd_d    = 1'b1;
    active_d = (state_q != S_IDLE);
    done_d   = (state_q == S_STOP) && bit_end;
    case (state_q)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shift_q[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sw_reset) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign TxD       = txd_q;
  assign tx_active = active_q;
  assign tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: per-cycle reference model, directed frame table and a line decoder.
module tb_uart_tx_buffered;

  localparam int C  = 4;
  localparam int D  = 4;
  localparam int CW = 3;
  localparam int FL = 10 * C;

  logic          clk = 1'b0;
  logic          sw_reset, wr_en;
  logic [7:0]    wr_data;
  logic          full, empty, overflow, TxD, tx_active, tx_done;
  logic [CW-1:0] count;

  uart_tx_buffered #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk       (clk),
    .sw_reset  (sw_reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .TxD       (TxD),
    .tx_active (tx_active),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queue of waiting bytes plus position within the current frame.
  logic [7:0] m_q[$];
  logic [7:0] acc_q[$];
  int         m_t = -1;
  logic [7:0] m_cur = 8'h00;
  logic       m_line = 1'b1, m_act = 1'b0, m_done = 1'b0, m_ovf = 1'b0;

  int         done_cnt = 0, act_cnt = 0, max_cnt = 0;
  logic [7:0] rx_q[$];
  int         frame_err = 0;
  logic       rx_on = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit pop, fullp;
    int k;
    if (sw_reset) begin
      m_q.delete();
      m_t = -1; m_line = 1'b1; m_act = 1'b0; m_done = 1'b0; m_ovf = 1'b0;
      return;
    end
    k = (m_t < 0) ? 0 : m_t / C;
    if (m_t < 0)       m_line = 1'b1;
    else if (k == 0)   m_line = 1'b0;
    else if (k == 9)   m_line = 1'b1;
    else               m_line = m_cur[k-1];
    m_act  = (m_t >= 0);
    m_done = (m_t == FL - 1);
    fullp  = (m_q.size() == D);
    pop    = (m_q.size() > 0) && (m_t < 0 || m_t == FL - 1);
    if (wr_en && fullp) m_ovf = 1'b1;
    if (pop) begin
      m_cur = m_q.pop_front();
      m_t   = 0;
    end else if (m_t == FL - 1) m_t = -1;
    else if (m_t >= 0)          m_t++;
    if (wr_en && !fullp) begin
      m_q.push_back(wr_data);
      acc_q.push_back(wr_data);
    end
  endtask

  task automatic step();
    logic [8:0] e, a;
    @(posedge clk);
    model_edge();
    #1;
    e = {m_line, m_act, m_done, m_q.size() == D, m_q.size() == 0, m_ovf, CW'(m_q.size())};
    a = {TxD, tx_active, tx_done, full, empty, overflow, count};
    check("cycle{txd,act,done,full,empty,ovf,cnt}", 32'(a), 32'(e));
    if (tx_done)   done_cnt++;
    if (tx_active) act_cnt++;
    if (int'(count) > max_cnt) max_cnt = int'(count);
  endtask

  task automatic idle(int n);
    wr_en = 1'b0;
    repeat (n) step();
  endtask

  task automatic write1(logic [7:0] b);
    wr_en = 1'b1; wr_data = b;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    sw_reset = 1'b1; step(); sw_reset = 1'b0;
  endtask

  task automatic check_rx(string nm, input logic [7:0] exp[$]);
    check({nm, "_rx_len"}, 32'(rx_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++)
      check({nm, "_rx_byte"}, 32'(rx_q[i]), 32'(exp[i]));
  endtask

  // Line decoder: samples mid-bit, independent of the DUT internals.
  initial begin : rx_dec
    logic [7:0] d;
    forever begin
      @(negedge clk);
      if (rx_on && TxD === 1'b0) begin
        repeat (C/2) @(negedge clk);
        if (TxD !== 1'b0) frame_err++;
        for (int i = 0; i < 8; i++) begin
          repeat (C) @(negedge clk);
          d[i] = TxD;
        end
        repeat (C) @(negedge clk);
        if (TxD !== 1'b1) frame_err++;
        rx_q.push_back(d);
      end
    end
  end

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;   // bit i = line level during the i-th bit period
  } vec_t;

  initial begin
    vec_t       vecs[5];
    logic [7:0] exp_q[$];
    int         sent;

    vecs[0] = '{8'hA5, 10'b1101001010};
    vecs[1] = '{8'h00, 10'b1000000000};
    vecs[2] = '{8'hFF, 10'b1111111110};
    vecs[3] = '{8'h01, 10'b1000000010};
    vecs[4] = '{8'h80, 10'b1100000000};

    // Reset, with writes attempted while reset is held.
    sw_reset = 1'b1; wr_en = 1'b1; wr_data = 8'h55;
    step(); step();
    check("rst_txd", TxD, 1); check("rst_active", tx_active, 0); check("rst_done", tx_done, 0);
    check("rst_count", count, 0); check("rst_empty", empty, 1); check("rst_full", full, 0);
    check("rst_ovf", overflow, 0);
    sw_reset = 1'b0; idle(3);
    check("rst_write_ignored", count, 0);

    // Directed single frames with latency check.
    rx_on = 1'b1;
    for (int i = 0; i < 5; i++) begin
      write1(vecs[i].data);
      check("lat_count_after_write", count, 1);
      step();
      check("lat_count_after_pop", count, 0);
      check("lat_line_still_idle", TxD, 1);
      for (int c = 0; c < FL; c++) begin
        step();
        check("frame_bit", TxD, vecs[i].line[c / C]);
        check("frame_done", tx_done, (c == FL - 1) ? 1 : 0);
      end
      step();
      check("frame_end_empty", empty, 1);
      check("frame_end_line", TxD, 1);
      check("frame_end_active", tx_active, 0);
    end
    exp_q.delete();
    for (int i = 0; i < 5; i++) exp_q.push_back(vecs[i].data);
    check_rx("table", exp_q);

    // Back-to-back burst.
    rx_q.delete(); done_cnt = 0; act_cnt = 0;
    for (int b = 1; b <= 3; b++) begin
      wr_en = 1'b1; wr_data = 8'(b); step();
    end
    idle(130);
    check("burst_done_pulses", done_cnt, 3);
    check("burst_active_cycles", act_cnt, 3 * FL);
    exp_q = '{8'h01, 8'h02, 8'h03};
    check_rx("burst", exp_q);

    // Overflow while a frame is running.
    rx_q.delete();
    write1(8'h10); idle(2);
    max_cnt = 0;
    for (int j = 1; j <= 5; j++) begin
      wr_en = 1'b1; wr_data = 8'h10 + 8'(j); step();
    end
    wr_en = 1'b0;
    check("ovf_peak_count", max_cnt, 4);
    check("ovf_full", full, 1);
    check("ovf_flag", overflow, 1);
    idle(5 * FL + 10);
    check("ovf_sticky", overflow, 1);
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    check_rx("ovf", exp_q);
    do_reset();
    check("ovf_cleared", overflow, 0);
    idle(2);

    // Write coinciding with a pop at count=2.
    rx_q.delete();
    write1(8'h20); idle(2); write1(8'h21); write1(8'h22);
    for (int g = 0; g < 100 && m_t != FL - 1; g++) step();
    check("same_edge_pre_count", count, 2);
    wr_en = 1'b1; wr_data = 8'h23; step(); wr_en = 1'b0;
    check("same_edge_count", count, 2);
    check("same_edge_full", full, 0);
    check("same_edge_empty", empty, 0);
    idle(4 * FL);
    exp_q = '{8'h20, 8'h21, 8'h22, 8'h23};
    check_rx("same_edge", exp_q);

    // Reset during data bit 3 with two bytes queued.
    idle(10);
    rx_on = 1'b0;
    for (int b = 0; b < 3; b++) begin
      wr_en = 1'b1; wr_data = 8'h30 + 8'(b); step();
    end
    wr_en = 1'b0;
    repeat (16) step();
    check("midrst_queued", count, 2);
    do_reset();
    check("midrst_txd", TxD, 1); check("midrst_count", count, 0);
    check("midrst_ovf", overflow, 0); check("midrst_active", tx_active, 0);
    done_cnt = 0; act_cnt = 0;
    idle(2 * FL);
    check("midrst_no_frames", done_cnt + act_cnt, 0);
    rx_q.delete(); frame_err = 0; rx_on = 1'b1;
    write1(8'h5A); idle(FL + 5);
    exp_q = '{8'h5A};
    check_rx("after_rst", exp_q);

    // Random traffic against the model.
    rx_q.delete(); acc_q.delete();
    for (int r = 0; r < 2000; r++) begin
      wr_en   = ($urandom_range(0, 9) < 2);
      wr_data = 8'($urandom);
      step();
    end
    idle((D + 1) * FL + 20);
    check_rx("random", acc_q);

    // Loopback of every byte value.
    do_reset(); idle(2);
    rx_q.delete(); acc_q.delete(); done_cnt = 0; sent = 0;
    for (int g = 0; g < 20000 && sent < 256; g++) begin
      if (m_q.size() < D) begin
        wr_en = 1'b1; wr_data = 8'(sent); sent++;
      end else wr_en = 1'b0;
      step();
    end
    idle((D + 1) * FL + 20);
    check("loop_sent", sent, 256);
    check("loop_done_pulses", done_cnt, 256);
    check("loop_ovf", overflow, 0);
    exp_q.delete();
    for (int i = 0; i < 256; i++) exp_q.push_back(8'(i));
    check_rx("loopback", exp_q);
    check("frame_errors", frame_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffered.md
UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clocks per serial bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 16, byte FIFO depth; power of two, 2..256.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 sw_reset  in  1  synchronous, active-high reset.
REQ-005 wr_en  in  1  write strobe; byte accepted when wr_en=1 and full=0.
REQ-006 wr_data  in  8  byte to queue.
REQ-007 full  out  1  FIFO holds FIFO_DEPTH bytes.
REQ-008 empty  out  1  FIFO holds zero bytes.
REQ-009 count  out  log2(FIFO_DEPTH)+1  bytes currently queued, excluding the byte being serialized.
REQ-010 overflow  out  1  sticky: set when wr_en=1 while full=1.
REQ-011 TxD  out  1  serial line, 8N1, idle high.
REQ-012 tx_active  out  1  high while a frame is on the line (start through stop bit).
REQ-013 tx_done  out  1  one-cycle pulse in the last cycle of each stop bit.

Function
REQ-014 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); every bit held exactly CLKS_PER_BIT cycles; frame length exactly 10*CLKS_PER_BIT cycles.
REQ-015 FSM states SHALL be IDLE, START, DATA, STOP; IDLE->START when FIFO non-empty (pop head into shift register same edge); START->DATA after CLKS_PER_BIT; DATA->STOP after 8 bits; STOP->START if FIFO non-empty at stop end (pop same edge), else STOP->IDLE.
REQ-016 Back-to-back frames SHALL have zero idle cycles between stop bit and next start bit.
REQ-017 Latency: byte accepted at edge N into empty FIFO with FSM in IDLE SHALL pop at edge N+1 and drive TxD=0 from edge N+2 onward.
REQ-018 TxD SHALL be driven from a register (glitch-free).
REQ-019 Write and pop on the same edge SHALL both take effect; count unchanged.
REQ-020 Write while full SHALL be dropped, FIFO contents unchanged, overflow set, even if a pop occurs the same edge.
REQ-021 Pointers SHALL wrap modulo FIFO_DEPTH; full/empty derived from count, never from pointer equality alone.
REQ-022 Bytes SHALL transmit in write order with no loss or duplication when overflow=0.
REQ-023 Bit counter SHALL be 3 bits; baud counter SHALL be wide enough for CLKS_PER_BIT-1 and reload to 0 at each bit boundary.

Reset
REQ-024 sw_reset=1 at an edge SHALL force: FSM=IDLE, TxD=1, tx_active=0, tx_done=0, count=0, empty=1, full=0, overflow=0, pointers=0, counters=0.
REQ-025 Reset mid-frame SHALL abort the frame; TxD high from the next edge; queued bytes discarded.
REQ-026 Writes while sw_reset=1 SHALL be ignored.

Structure
REQ-027 Shared package uart_pkg SHALL hold FSM state encoding, DATA_BITS=8, and the default CLKS_PER_BIT constant shared with uart_rx/uart_tx.
REQ-028 FIFO SHALL be a sub-module byte_fifo (sync, registered count, first-word presented on rd_data without read latency); serializer FSM lives in uart_tx_buffered.

Verification (sim with CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-029 Single byte 0xA5 written to idle block -> TxD=0 from edge N+2; line samples 0,1,0,1,0,0,1,0,1,1 each 4 cycles; tx_done pulses once at cycle 40 of frame; empty=1 after.
REQ-030 Burst write 0x01,0x02,0x03 on consecutive cycles -> three contiguous 40-cycle frames, no idle gap, decoded order 01,02,03, tx_done pulses 3 times.
REQ-031 Write 6 bytes while first frame running -> count peaks at 4, full=1, 6th write dropped, overflow=1 sticky; 5 bytes transmitted in order.
REQ-032 Write and pop on same edge with count=2 -> count stays 2; full and empty unchanged.
REQ-033 Assert sw_reset during data bit 3 of frame with 2 bytes queued -> TxD=1 next edge, count=0, no further frames, overflow=0; new write after reset transmits normally.
REQ-034 Loopback: TxD fed into uart_rx with matching CLKS_PER_BIT, 256 bytes 0x00..0xFF -> every byte received in order, done_reading pulses 256 times.
